// File: rtl/dcache_stall.sv
// Direct-mapped, write-back, write-allocate data cache with an explicit stall
// output and a request/acknowledge line interface to memory.
module dcache_stall #(
    parameter int unsigned DSIZE      = 16,
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned NUM_LINES  = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [DSIZE-1:0]              addr,
    input  logic [DSIZE-1:0]              cache_data_in,
    output logic [DSIZE-1:0]              cache_data_out,
    output logic                          stall,
    output logic                          write_back,
    output logic [DSIZE-$clog2(LINE_WORDS)-1:0] wb_addr,
    output logic [DSIZE*LINE_WORDS-1:0]   wb_data,
    output logic                          fetch_req,
    output logic [DSIZE-$clog2(LINE_WORDS)-1:0] fetch_addr,
    input  logic [DSIZE*LINE_WORDS-1:0]   fetch_data,
    input  logic                          mem_ack,
    output logic [CNT_W-1:0]              hit_count,
    output logic [CNT_W-1:0]              miss_count
);

    localparam int unsigned OFF    = $clog2(LINE_WORDS);
    localparam int unsigned IDX    = $clog2(NUM_LINES);
    localparam int unsigned TAG    = DSIZE - IDX - OFF;
    localparam int unsigned LINE_W = DSIZE * LINE_WORDS;

    typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

    state_e state_q, state_d;
    logic   replay_q;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG-1:0]       tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    logic [CNT_W-1:0] hit_count_q;
    logic [CNT_W-1:0] miss_count_q;

    logic [OFF-1:0]    offset;
    logic [IDX-1:0]    index;
    logic [TAG-1:0]    tag;
    logic [LINE_W-1:0] line;
    logic              req;
    logic              hit;
    logic              write_hit;
    logic              hit_event;
    logic              miss_event;
    logic              fill_done;

    assign offset = addr[OFF-1:0];
    assign index  = addr[OFF+IDX-1:OFF];
    assign tag    = addr[DSIZE-1:OFF+IDX];
    assign line   = data_q[index];

    assign req = mem_read | mem_write;
    assign hit = req & valid_q[index] & (tag_q[index] == tag);

    // A simultaneous read+write is a write, so only mem_write decides the store.
    assign write_hit = (state_q == StIdle) & hit & mem_write;
    // The hit that completes a replayed miss was already counted as a miss.
    assign hit_event = (state_q == StIdle) & hit & ~replay_q;

    assign cache_data_out = hit ? line[int'(offset)*DSIZE +: DSIZE] : '0;
    assign wb_addr        = {tag_q[index], index};
    assign wb_data        = line;
    assign fetch_addr     = addr[DSIZE-1:OFF];
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        write_back = 1'b0;
        fetch_req  = 1'b0;
        miss_event = 1'b0;
        fill_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    stall      = 1'b1;
                    miss_event = 1'b1;
                    state_d    = (valid_q[index] && dirty_q[index]) ? StWb : StFill;
                end
            end
            StWb: begin
                stall      = 1'b1;
                write_back = 1'b1;
                if (mem_ack) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                stall     = 1'b1;
                fetch_req = 1'b1;
                if (mem_ack) begin
                    fill_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and one-cycle replay marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            replay_q <= fill_done;
        end
    end

    // Valid and dirty bits; a fill always lands clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag and line data; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[index] <= fetch_data;
            tag_q[index]  <= tag;
        end else if (write_hit) begin
            data_q[index][int'(offset)*DSIZE +: DSIZE] <= cache_data_in;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit_event && hit_count_q != '1) begin
                hit_count_q <= hit_count_q + 1'b1;
            end
            if (miss_event && miss_count_q != '1) begin
                miss_count_q <= miss_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_stall.sv
// Directed bench for dcache_stall with a latency-programmable memory model.
module tb_dcache_stall;

    localparam int unsigned DSIZE  = 16;
    localparam int unsigned LW     = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LINE_W = DSIZE * LW;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read;
    logic              mem_write;
    logic [15:0]       addr;
    logic [15:0]       cache_data_in;
    logic [15:0]       cache_data_out;
    logic              stall;
    logic              write_back;
    logic [11:0]       wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              fetch_req;
    logic [11:0]       fetch_addr;
    logic [LINE_W-1:0] fetch_data;
    logic              mem_ack;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the last access.
    int          stall_cyc;
    bit          wb_seen;
    bit          overlap_seen;
    logic [11:0] wb_addr_seen;
    logic [15:0] wb_word3_seen;
    logic [11:0] fetch_addr_seen;
    logic [15:0] rdata;

    dcache_stall #(
        .DSIZE      (DSIZE),
        .LINE_WORDS (LW),
        .NUM_LINES  (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .addr           (addr),
        .cache_data_in  (cache_data_in),
        .cache_data_out (cache_data_out),
        .stall          (stall),
        .write_back     (write_back),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .mem_ack        (mem_ack),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] pat(input logic [15:0] base);
        logic [LINE_W-1:0] p;
        for (int i = 0; i < LW; i++) begin
            p[i*DSIZE +: DSIZE] = base + 16'(i);
        end
        return p;
    endfunction

    // Holds a request until stall drops, acking each transfer on its lat-th cycle.
    task automatic access(input logic [15:0] a, input bit wr, input logic [15:0] wd,
                          input int lat, input logic [15:0] fill_base);
        bit done = 0;
        int wb_cnt = 0;
        int f_cnt = 0;
        mem_read      = ~wr;
        mem_write     = wr;
        addr          = a;
        cache_data_in = wd;
        fetch_data    = pat(fill_base);
        stall_cyc     = 0;
        wb_seen       = 0;
        overlap_seen  = 0;
        wb_addr_seen  = '0;
        wb_word3_seen = '0;
        fetch_addr_seen = '0;
        rdata         = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (!stall) begin
                done  = 1;
                rdata = cache_data_out;
            end else begin
                stall_cyc++;
                if (write_back && fetch_req) overlap_seen = 1;
                if (write_back) begin
                    if (!wb_seen) begin
                        wb_addr_seen  = wb_addr;
                        wb_word3_seen = wb_data[3*DSIZE +: DSIZE];
                    end
                    wb_seen = 1;
                    wb_cnt++;
                    if (wb_cnt == lat) mem_ack = 1'b1;
                end
                if (fetch_req) begin
                    if (f_cnt == 0) fetch_addr_seen = fetch_addr;
                    f_cnt++;
                    if (f_cnt == lat) mem_ack = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        if (!done) check_eq("access_timeout", 32'(stall_cyc), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        addr          = '0;
        cache_data_in = '0;
        fetch_data    = '0;
        mem_ack       = 1'b0;
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_fetch_req", 32'(fetch_req), 32'd0);
        check_eq("rst_write_back", 32'(write_back), 32'd0);
        check_eq("rst_data_out", 32'(cache_data_out), 32'd0);
        check_eq("rst_hit_count", 32'(hit_count), 32'd0);
        check_eq("rst_miss_count", 32'(miss_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean miss, ack on the third fetch cycle.
        access(16'h0123, 0, 16'h0, 3, 16'hA000);
        check_eq("miss_stall_cycles", 32'(stall_cyc), 32'd4);
        check_eq("miss_fetch_addr", 32'(fetch_addr_seen), 32'h012);
        check_eq("miss_no_wb", 32'(wb_seen), 32'd0);
        check_eq("miss_rdata", 32'(rdata), 32'hA003);
        check_eq("miss_miss_count", 32'(miss_count), 32'd1);
        check_eq("miss_hit_count", 32'(hit_count), 32'd0);

        // Write hit then read hit.
        access(16'h0123, 1, 16'hBEEF, 1, 16'h0);
        check_eq("wr_hit_stall", 32'(stall_cyc), 32'd0);
        access(16'h0123, 0, 16'h0, 1, 16'h0);
        check_eq("rd_hit_stall", 32'(stall_cyc), 32'd0);
        check_eq("rd_hit_data", 32'(rdata), 32'hBEEF);
        check_eq("hits_after_wr_rd", 32'(hit_count), 32'd2);

        // Dirty conflict miss: write back then fill.
        access(16'h0823, 0, 16'h0, 2, 16'hB000);
        check_eq("dirty_wb_seen", 32'(wb_seen), 32'd1);
        check_eq("dirty_wb_addr", 32'(wb_addr_seen), 32'h012);
        check_eq("dirty_wb_word3", 32'(wb_word3_seen), 32'hBEEF);
        check_eq("dirty_fetch_addr", 32'(fetch_addr_seen), 32'h082);
        check_eq("dirty_stall_cycles", 32'(stall_cyc), 32'd5);
        check_eq("dirty_rdata", 32'(rdata), 32'hB003);
        check_eq("dirty_no_overlap", 32'(overlap_seen), 32'd0);
        check_eq("dirty_miss_count", 32'(miss_count), 32'd2);
        check_eq("dirty_hit_count", 32'(hit_count), 32'd2);

        // Clean conflict miss goes straight to fill.
        access(16'h0123, 0, 16'h0, 1, 16'hA000);
        check_eq("clean_no_wb", 32'(wb_seen), 32'd0);
        check_eq("clean_stall_cycles", 32'(stall_cyc), 32'd2);
        check_eq("clean_rdata", 32'(rdata), 32'hA003);
        check_eq("clean_miss_count", 32'(miss_count), 32'd3);

        // Write miss merges into the filled line on replay.
        access(16'h0455, 1, 16'h1234, 1, 16'hC000);
        check_eq("wmiss_stall_cycles", 32'(stall_cyc), 32'd2);
        access(16'h0455, 0, 16'h0, 1, 16'h0);
        check_eq("wmiss_merged", 32'(rdata), 32'h1234);
        access(16'h0456, 0, 16'h0, 1, 16'h0);
        check_eq("wmiss_neighbour", 32'(rdata), 32'hC006);
        check_eq("wmiss_hit_count", 32'(hit_count), 32'd4);
        check_eq("wmiss_miss_count", 32'(miss_count), 32'd4);

        // Idle cycles leave everything alone.
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_stall", 32'(stall), 32'd0);
        check_eq("idle_hit_count", 32'(hit_count), 32'd4);

        // Reset in the middle of a fill.
        mem_read = 1'b1;
        addr     = 16'h0777;
        for (int c = 0; c < 10 && !fetch_req; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_fill_reached", 32'(fetch_req), 32'd1);
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        check_eq("midrst_fetch_req", 32'(fetch_req), 32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);
        check_eq("midrst_miss_count", 32'(miss_count), 32'd0);
        check_eq("midrst_hit_count", 32'(hit_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(16'h0123, 0, 16'h0, 1, 16'hA000);
        check_eq("rerd_stall_cycles", 32'(stall_cyc), 32'd2);
        check_eq("rerd_miss_count", 32'(miss_count), 32'd1);

        // Twenty back-to-back hits saturate the 4-bit counter.
        mem_read = 1'b1;
        addr     = 16'h0123;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        mem_read = 1'b0;
        check_eq("sat_hit_count", 32'(hit_count), 32'hF);
        check_eq("sat_miss_count", 32'(miss_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
